// File: rtl/sdram_burst_controller_if.sv
// Handshake bundle between a cache's fill/write-back logic and sdram_burst_controller.
interface sdram_burst_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              rdata_last;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, wdata, wdata_valid,
        input  req_ready, wdata_ready, rdata, rdata_valid, rdata_last, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, wdata, wdata_valid,
        output req_ready, wdata_ready, rdata, rdata_valid, rdata_last, busy
    );
endinterface

// File: rtl/sdram_burst_controller.sv
// Burst memory model with wrapping fixed-length bursts, programmable read latency and
// valid/ready handshakes; contents survive reset.
module sdram_burst_controller #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int BURST_LEN    = 4,
    parameter int RD_LATENCY   = 2,
    parameter int INIT_PATTERN = 1
) (
    input logic clk,
    input logic rst,
    sdram_burst_controller_if.slave bus
);
    localparam int L     = $clog2(BURST_LEN);
    localparam int CW    = L + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, READ} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     beat;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] beat_addr;
    logic              we;

    // Storage holds each word XOR its preload value, so an all-zero array reads back
    // as the preload pattern without any run-time initialisation.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
        return (INIT_PATTERN != 0) ? DATA_W'(a) : '0;
    endfunction

    // Low L bits advance modulo BURST_LEN, keeping the burst inside its aligned block.
    assign beat_addr = {base[ADDR_W-1:L], base[L-1:0] + beat[L-1:0]};
    assign we        = (state == WRITE) && bus.wdata_valid;

    assign bus.req_ready   = (state == IDLE) && !rst;
    assign bus.wdata_ready = (state == WRITE);
    assign bus.busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (we) mem[beat_addr] <= bus.wdata ^ preload(beat_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            base            <= '0;
            beat            <= '0;
            lat_cnt         <= '0;
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
            bus.rdata_last  <= 1'b0;
        end else begin
            bus.rdata_valid <= 1'b0;
            bus.rdata_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base    <= bus.req_addr;
                        beat    <= '0;
                        lat_cnt <= '0;
                        if (bus.req_wr)           state <= WRITE;
                        else if (RD_LATENCY == 1) state <= READ;
                        else                      state <= RD_WAIT;
                    end
                end
                WRITE: begin
                    if (bus.wdata_valid) begin
                        beat <= beat + 1'b1;
                        if (beat == CW'(BURST_LEN - 1)) state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_W'(RD_LATENCY - 2)) state <= READ;
                    else lat_cnt <= lat_cnt + 1'b1;
                end
                READ: begin
                    // One trailing cycle after the last beat keeps req_ready low while it is on the bus.
                    if (beat == CW'(BURST_LEN)) begin
                        state <= IDLE;
                    end else begin
                        bus.rdata       <= mem[beat_addr] ^ preload(beat_addr);
                        bus.rdata_valid <= 1'b1;
                        bus.rdata_last  <= (beat == CW'(BURST_LEN - 1));
                        beat            <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_burst_controller.sv
// Four controller instances (latency 2/1/5 at 8 bits, and 32-bit x 8-beat) driven from
// shared stimulus and checked against an address-level reference memory.
module tb_sdram_burst_controller;
    localparam int AW = 16;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          req_valid = 1'b0, req_wr = 1'b0, wdata_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   wdata = '0;
    logic [ND-1:0] en = '1;

    sdram_burst_controller_if #(.ADDR_W(AW), .DATA_W(8))  b0 (), b1 (), b2 ();
    sdram_burst_controller_if #(.ADDR_W(AW), .DATA_W(32)) b3 ();

    assign b0.req_valid = req_valid & en[0];
    assign b1.req_valid = req_valid & en[1];
    assign b2.req_valid = req_valid & en[2];
    assign b3.req_valid = req_valid & en[3];
    assign b0.req_wr = req_wr;  assign b1.req_wr = req_wr;  assign b2.req_wr = req_wr;  assign b3.req_wr = req_wr;
    assign b0.req_addr = req_addr;  assign b1.req_addr = req_addr;
    assign b2.req_addr = req_addr;  assign b3.req_addr = req_addr;
    assign b0.wdata = wdata[7:0];  assign b1.wdata = wdata[7:0];  assign b2.wdata = wdata[7:0];  assign b3.wdata = wdata;
    assign b0.wdata_valid = wdata_valid;  assign b1.wdata_valid = wdata_valid;
    assign b2.wdata_valid = wdata_valid;  assign b3.wdata_valid = wdata_valid;

    sdram_burst_controller #(.RD_LATENCY(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
    sdram_burst_controller #(.RD_LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    sdram_burst_controller #(.RD_LATENCY(5)) u2 (.clk(clk), .rst(rst), .bus(b2));
    sdram_burst_controller #(.DATA_W(32), .BURST_LEN(8)) u3 (.clk(clk), .rst(rst), .bus(b3));

    logic [ND-1:0] rr, wrdy, bsy, vld, lst;
    logic [31:0]   rd [ND];
    assign rr   = {b3.req_ready,   b2.req_ready,   b1.req_ready,   b0.req_ready};
    assign wrdy = {b3.wdata_ready, b2.wdata_ready, b1.wdata_ready, b0.wdata_ready};
    assign bsy  = {b3.busy,        b2.busy,        b1.busy,        b0.busy};
    assign vld  = {b3.rdata_valid, b2.rdata_valid, b1.rdata_valid, b0.rdata_valid};
    assign lst  = {b3.rdata_last,  b2.rdata_last,  b1.rdata_last,  b0.rdata_last};
    assign rd[0] = 32'(b0.rdata);
    assign rd[1] = 32'(b1.rdata);
    assign rd[2] = 32'(b2.rdata);
    assign rd[3] = b3.rdata;

    typedef struct { int dut; int cyc; logic [31:0] d; logic last; } beat_t;
    beat_t mq[$];
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++)
            if (vld[i]) mq.push_back('{i, cyc, rd[i], lst[i]});
    end

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 8-bit instances share one memory image; the 32-bit one only ever holds its preload.
    logic [7:0] mem8 [1 << AW];
    logic [7:0] wd [4];

    function automatic int lat_of(input int d);
        return (d == 1) ? 1 : (d == 2) ? 5 : 2;
    endfunction
    function automatic int bl_of(input int d);
        return (d == 3) ? 8 : 4;
    endfunction
    function automatic int beat_addr(input int a, input int k, input int bl);
        return (a - (a % bl)) + ((a % bl) + k) % bl;
    endfunction
    function automatic logic [31:0] exp_word(input int d, input int a);
        return (d == 3) ? 32'(a) : 32'(mem8[a]);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s d%0d req_ready", tag, i), 32'(rr[i]), 32'd0);
            chk($sformatf("%s d%0d wdata_ready", tag, i), 32'(wrdy[i]), 32'd0);
            chk($sformatf("%s d%0d busy", tag, i), 32'(bsy[i]), 32'd0);
            chk($sformatf("%s d%0d rdata_valid", tag, i), 32'(vld[i]), 32'd0);
            chk($sformatf("%s d%0d rdata_last", tag, i), 32'(lst[i]), 32'd0);
            chk($sformatf("%s d%0d rdata", tag, i), rd[i], 32'd0);
        end
    endtask

    task automatic rd_burst(input int a, input logic [ND-1:0] m, input bit keep);
        int t0;
        int k;
        int done [ND];
        bit all;
        mq.delete();
        en = m; req_wr = 1'b0; req_addr = AW'(a); req_valid = 1'b1;
        for (int i = 0; i < ND; i++)
            if (m[i]) chk($sformatf("rd@%0h d%0d req_ready before", a, i), 32'(rr[i]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        if (!keep) req_valid = 1'b0;
        for (int i = 0; i < ND; i++) done[i] = 0;
        for (int c = 0; c < 40; c++) begin
            all = 1'b1;
            for (int i = 0; i < ND; i++)
                if (m[i] && done[i] == 0) begin
                    if (rr[i]) done[i] = cyc;
                    else all = 1'b0;
                end
            if (all) break;
            @(negedge clk);
        end
        for (int i = 0; i < ND; i++) begin
            if (!m[i]) continue;
            chk($sformatf("rd@%0h d%0d ready-again cycle", a, i), 32'(done[i]),
                32'(t0 + lat_of(i) + bl_of(i)));
            k = 0;
            foreach (mq[j]) begin
                if (mq[j].dut != i) continue;
                if (k < bl_of(i)) begin
                    chk($sformatf("rd@%0h d%0d b%0d cycle", a, i, k), 32'(mq[j].cyc), 32'(t0 + lat_of(i) + k));
                    chk($sformatf("rd@%0h d%0d b%0d data", a, i, k), mq[j].d, exp_word(i, beat_addr(a, k, bl_of(i))));
                    chk($sformatf("rd@%0h d%0d b%0d last", a, i, k), 32'(mq[j].last), 32'(k == bl_of(i) - 1));
                end
                k++;
            end
            chk($sformatf("rd@%0h d%0d beat count", a, i), 32'(k), 32'(bl_of(i)));
        end
    endtask

    // Writes wd[0..3]; stall_n idle cycles are inserted before beat stall_at; abort_at asserts reset
    // after that many beats have committed.
    task automatic wr_burst(input int a, input logic [ND-1:0] m, input int stall_at, input int stall_n,
                            input bit keep, input int abort_at);
        en = m; req_wr = 1'b1; req_addr = AW'(a); req_valid = 1'b1;
        wdata_valid = keep; wdata = 32'hEE;
        for (int i = 0; i < ND; i++)
            if (m[i]) chk($sformatf("wr@%0h d%0d req_ready before", a, i), 32'(rr[i]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk_reset_outputs("abort");
                wdata_valid = 1'b0; req_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                for (int i = 0; i < ND; i++)
                    chk($sformatf("abort release d%0d req_ready", i), 32'(rr[i]), 32'd1);
                @(negedge clk);
                return;
            end
            if (k == stall_at) begin
                repeat (stall_n) begin
                    wdata_valid = 1'b0;
                    @(negedge clk);
                end
            end
            for (int i = 0; i < ND; i++) begin
                if (m[i]) begin
                    chk($sformatf("wr@%0h d%0d b%0d wdata_ready", a, i, k), 32'(wrdy[i]), 32'd1);
                    chk($sformatf("wr@%0h d%0d b%0d req_ready", a, i, k), 32'(rr[i]), 32'd0);
                end
            end
            wdata = 32'(wd[k]); wdata_valid = 1'b1;
            @(posedge clk);
            mem8[beat_addr(a, k, 4)] = wd[k];
            @(negedge clk);
        end
        wdata_valid = keep; wdata = 32'hEE;
        for (int i = 0; i < ND; i++)
            if (m[i]) chk($sformatf("wr@%0h d%0d req_ready after", a, i), 32'(rr[i]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int wa;
        for (int i = 0; i < (1 << AW); i++) mem8[i] = 8'(i);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) chk($sformatf("release d%0d req_ready", i), 32'(rr[i]), 32'd1);
        @(negedge clk);

        rd_burst(16'h1236, 4'b0111, 1'b0);

        wd = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        wr_burst(16'h00F0, 4'b0111, 2, 2, 1'b0, -1);
        rd_burst(16'h00F0, 4'b0111, 1'b0);
        rd_burst(16'h00F4, 4'b0111, 1'b0);

        wd = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_burst(16'hFFFF, 4'b0111, 4, 0, 1'b0, -1);
        rd_burst(16'hFFFC, 4'b0111, 1'b0);
        rd_burst(16'h0000, 4'b0111, 1'b0);

        rd_burst(16'h0040, 4'b0111, 1'b0);

        wd = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
        wr_burst(16'h0100, 4'b0111, 4, 0, 1'b0, 2);
        rd_burst(16'h0100, 4'b0111, 1'b0);

        rd_burst(16'h0007, 4'b1000, 1'b0);
        for (int n = 0; n < 3; n++) begin
            a = int'($urandom_range(0, 65535));
            rd_burst(a, 4'b1000, 1'b0);
        end

        for (int n = 0; n < 8; n++) begin
            a = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) wd[k] = 8'($urandom);
                wr_burst(a, 4'b0111, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0, -1);
            end
            rd_burst(int'($urandom_range(0, 65535)), 4'b0111, 1'b0);
            rd_burst(a, 4'b0111, 1'b0);
        end

        // Back-to-back on the latency-2 instance: req_valid and wdata_valid never drop.
        wa = 0;
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) begin
                wa = int'($urandom_range(0, 65535));
                for (int k = 0; k < 4; k++) wd[k] = 8'($urandom);
                wr_burst(wa, 4'b0001, 4, 0, 1'b1, -1);
            end else begin
                rd_burst(wa, 4'b0001, 1'b1);
            end
        end
        req_valid = 1'b0; wdata_valid = 1'b0;
        @(negedge clk);
        rd_burst(wa, 4'b0001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_burst_controller.md
# sdram_burst_controller

Parametrised burst-capable memory model and controller serving cache line fills and write-backs. It generalises the single-byte strobe memory to configurable data and address widths, fixed-length wrapping bursts, programmable read latency and valid/ready handshakes. It sits between the cache controller's miss/eviction logic and the backing store. Memory contents are preloaded at elaboration and are not touched by reset.

## Interface
- ADDR_W, 16, word address width; depth = 2^ADDR_W words
- DATA_W, 8, word width in bits
- BURST_LEN, 4, beats per burst; power of two, 2..16
- RD_LATENCY, 2, cycles from request accept to first read beat; 1..8
- INIT_PATTERN, 1, 1: word i preloaded with i[DATA_W-1:0] (zero-extended if DATA_W > ADDR_W); 0: all zeros
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_wr  input  1  1 = write burst, 0 = read burst
- req_addr  input  ADDR_W  critical (first) word address
- wdata  input  DATA_W  write beat data
- wdata_valid  input  1  write beat present
- wdata_ready  output  1  controller accepts write beat
- rdata  output  DATA_W  read beat data
- rdata_valid  output  1  read beat valid; no backpressure
- rdata_last  output  1  final beat of read burst
- busy  output  1  burst in progress (state != IDLE)

## Operation
- Reset values: req_ready=0 while rst is high, 1 in the first cycle after release; wdata_ready=0, rdata=0, rdata_valid=0, rdata_last=0, busy=0.
- FSM states: IDLE, WRITE, RD_WAIT, READ.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches req_wr and req_addr. It goes to WRITE if req_wr=1. Otherwise it goes to RD_WAIT, or directly to READ when RD_LATENCY=1.
- Beat address: beat k (0..BURST_LEN-1) uses {base[ADDR_W-1:L], (base[L-1:0]+k) mod BURST_LEN}, where L = log2(BURST_LEN). The burst wraps within its aligned block and never crosses into the next block.
- Burst address wrap: an address at the top of memory wraps within its block, never to address 0 of the next block.
- WRITE: wdata_ready=1. Each wdata_valid & wdata_ready handshake writes wdata to the current beat address and increments the beat counter. Cycles without wdata_valid stall and do not advance the counter. After BURST_LEN handshakes the FSM returns to IDLE.
- RD_WAIT: a counter spends RD_LATENCY-1 cycles in this state, then moves to READ.
- READ: one beat per cycle for BURST_LEN consecutive cycles. rdata is registered from the beat address. rdata_last=1 on beat BURST_LEN-1. The FSM then returns to IDLE.
- Outside READ: rdata_valid=0 and rdata_last=0. rdata holds its last value.
- Write-then-read of the same address returns the newly written data, because the FSM runs one burst at a time.
- Reset mid-burst: the burst is aborted and the FSM goes to IDLE. Beats already written stay in memory. rdata_valid and wdata_ready drop immediately (asynchronous).

## Timing
- Request accepted at rising edge T0.
- Read: rdata_valid is high in the cycles after edges T0+RD_LATENCY through T0+RD_LATENCY+BURST_LEN-1. req_ready returns high in the cycle after the last beat.
- Minimum read turnaround (request to request): RD_LATENCY+BURST_LEN+1 cycles.
- Write: wdata_ready is high starting the cycle after T0. With continuous wdata_valid, the last write commits at edge T0+BURST_LEN. req_ready is high the following cycle.
- req_ready, wdata_ready and busy are decoded from registered state only (no combinational path from inputs).
- wdata_valid asserted while not in WRITE is ignored.

## Test plan
- Reset, defaults: read req_addr=0x1236. Beats must be 0x36, 0x37, 0x34, 0x35, starting 2 cycles after accept; rdata_last on 0x35.
- Write burst at 0x00F0 with data A0..A3, with wdata_valid deasserted for 2 cycles between beats 1 and 2. Read back at 0x00F0 -> A0, A1, A2, A3. Address 0x00F4 must be unchanged (0xF4).
- Wrapping write at 0xFFFF with data 11, 22, 33, 44. Must land at 0xFFFF, 0xFFFC, 0xFFFD, 0xFFFE. Address 0x0000 must still read 0x00.
- Latency sweep with RD_LATENCY=1 and RD_LATENCY=5 on read 0x0040. The first valid beat must appear exactly 1 and 5 cycles after accept; req_ready stays low throughout the burst.
- Reset after 2 beats of a write at 0x0100 (data 5A, 5B, ...). Outputs go to reset values immediately. Read 0x0100 afterwards -> 5A, 5B, 0x02, 0x03.
- Back-to-back: hold req_valid high with alternating read/write. Each request must be accepted only in IDLE, with no beat lost or duplicated. DATA_W=32 and BURST_LEN=8 variant: read 0x0007 -> 0x07, 0x00, 0x01, ..., 0x06.
